// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time over a
// req/ack memory handshake, presents opcode/funct to the decoder, and resolves
// the next PC from the decoder's jump/branch result once execution completes.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [15:0] STALL_LIMIT = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic [1:0]  ctl_jump,
    input  logic        ctl_branch,
    input  logic        alu_zero,
    input  logic [31:0] rs_value,
    input  logic        ex_done,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic [15:0] stall_q, stall_d;

    logic [31:0] pc4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        branch_taken;
    logic [31:0] next_pc;
    logic        jr_misaligned;
    logic [15:0] stall_inc;

    assign pc4           = pc_q + 32'd4;
    assign jump_target   = {pc4[31:28], instr_q[25:0], 2'b00};
    assign branch_target = pc4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign jr_misaligned = (ctl_jump == 2'b10) && (rs_value[1:0] != 2'b00);
    assign stall_inc     = stall_q + 16'd1;

    // Branch resolution: only beq/bne can be taken, keyed off the held opcode.
    always_comb begin
        branch_taken = 1'b0;
        if (ctl_branch) begin
            if (instr_q[31:26] == OP_BEQ) begin
                branch_taken = alu_zero;
            end else if (instr_q[31:26] == OP_BNE) begin
                branch_taken = !alu_zero;
            end
        end
    end

    // Next-PC select in priority order: j, jr, taken branch, sequential (jump=11 is sequential).
    always_comb begin
        next_pc = pc4;
        if (ctl_jump == 2'b01) begin
            next_pc = jump_target;
        end else if (ctl_jump == 2'b10) begin
            next_pc = rs_value;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    // Control FSM next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        err_d   = err_q;
        stall_d = stall_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end else begin
                    stall_d = stall_inc;
                    if ((STALL_LIMIT != 16'd0) && (stall_inc == STALL_LIMIT)) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (ex_done) begin
                    if (jr_misaligned) begin
                        // Misaligned jr target: fault and keep the faulting PC visible.
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        stall_d = 16'd0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; async reset clears outputs without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            err_q   <= 1'b0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    // Outputs are decoded from registered state only, so they glitch-free follow reset.
    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_DECODE);
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign pc          = pc_q;
    assign pc_plus4    = pc4;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// instruction streams checked against a behavioural next-PC model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [1:0]  ctl_jump = 2'b00;
    logic        ctl_branch = 1'b0;
    logic        alu_zero = 1'b0;
    logic [31:0] rs_value = 32'd0;
    logic        ex_done = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_pc;
    logic [31:0] model_instr;
    logic        model_halt;

    instr_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .STALL_LIMIT (16'd4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .funct       (funct),
        .instr_valid (instr_valid),
        .ctl_jump    (ctl_jump),
        .ctl_branch  (ctl_branch),
        .alu_zero    (alu_zero),
        .rs_value    (rs_value),
        .ex_done     (ex_done),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // Reference next PC, straight from the architectural rules.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] iw,
                                             input logic [1:0] j, input logic b, input logic z,
                                             input logic [31:0] rs, output logic halt);
        logic [31:0] seq;
        int          off;
        int unsigned op;
        seq  = cur + 32'd4;
        halt = 1'b0;
        op   = iw >> 26;
        off  = int'($signed(iw[15:0]));
        if (j == 2'd1) return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
        if (j == 2'd2) begin
            if (rs % 4 != 0) begin
                halt = 1'b1;
                return cur;
            end
            return rs;
        end
        if (b && ((op == 4 && z) || (op == 5 && !z))) return seq + 32'(off * 4);
        return seq;
    endfunction

    task automatic apply_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        ex_done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_pc    = 32'h0;
        model_instr = 32'h0;
        model_halt  = 1'b0;
    endtask

    // Fetch one word with dly no-ack cycles first; checks handshake and decode pulse.
    task automatic do_fetch(input logic [31:0] w, input int dly);
        for (int i = 0; i <= dly; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== model_pc) begin
                errors++;
                $display("FAIL fetch_req: req=%b addr=%h, required req=1 addr=%h",
                         imem_req, imem_addr, model_pc);
            end
            checks++;
            if (instr !== model_instr || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL fetch_hold: instr=%h valid=%b, required instr=%h valid=0",
                         instr, instr_valid, model_instr);
            end
            imem_ack   = (i == dly);
            imem_rdata = (i == dly) ? w : $urandom;
            @(negedge clk);
        end
        imem_ack    = 1'b0;
        model_instr = w;
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b0 || opcode !== w[31:26] || funct !== w[5:0]) begin
            errors++;
            $display("FAIL decode: valid=%b req=%b op=%h fn=%h, required valid=1 req=0 op=%h fn=%h",
                     instr_valid, imem_req, opcode, funct, w[31:26], w[5:0]);
        end
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || instr !== w) begin
            errors++;
            $display("FAIL decode_pulse: valid=%b instr=%h, required valid=0 instr=%h",
                     instr_valid, instr, w);
        end
    endtask

    // Execute with dly cycles before ex_done; stray acks are driven meanwhile.
    task automatic do_exec(input logic [1:0] j, input logic b, input logic z,
                           input logic [31:0] rs, input int dly);
        logic [31:0] exp_pc;
        logic        exp_halt;
        for (int i = 0; i < dly; i++) begin
            ctl_jump   = 2'($urandom);
            rs_value   = 32'h3;
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            @(negedge clk);
            checks++;
            if (pc_plus4 !== model_pc + 32'd4 || instr !== model_instr || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL exec_wait: pc4=%h instr=%h req=%b, required pc4=%h instr=%h req=0",
                         pc_plus4, instr, imem_req, model_pc + 32'd4, model_instr);
            end
        end
        imem_ack   = 1'b0;
        ctl_jump   = j;
        ctl_branch = b;
        alu_zero   = z;
        rs_value   = rs;
        ex_done    = 1'b1;
        exp_pc     = ref_next(model_pc, model_instr, j, b, z, rs, exp_halt);
        @(negedge clk);
        ex_done    = 1'b0;
        ctl_jump   = 2'b00;
        ctl_branch = 1'b0;
        model_pc   = exp_pc;
        model_halt = exp_halt;
        checks++;
        if (pc !== exp_pc || fetch_err !== exp_halt || imem_req !== !exp_halt) begin
            errors++;
            $display("FAIL exec_next: pc=%h err=%b req=%b, required pc=%h err=%b req=%b",
                     pc, fetch_err, imem_req, exp_pc, exp_halt, !exp_halt);
        end
    endtask

    task automatic goto_pc(input logic [31:0] target);
        do_fetch(32'h0000_0008, 0);
        do_exec(2'b10, 1'b0, 1'b0, target, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0
            || fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: req=%b pc=%h instr=%h valid=%b err=%b, required all 0",
                     imem_req, pc, instr, instr_valid, fetch_err);
        end
        apply_reset();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
        end
        // Reset mid-fetch with an ack in flight: request drops at once, ack is discarded.
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: req=%b pc=%h, required req=0 pc=0", imem_req, pc);
        end
        @(negedge clk);
        checks++;
        if (instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_ack_drop: instr=%h, required 00000000", instr);
        end
        apply_reset();
    endtask

    task automatic test_seq();
        do_fetch(32'h2008_0005, 0);
        checks++;
        if (opcode !== 6'h08) begin
            errors++;
            $display("FAIL seq_opcode: opcode=%h, required 08", opcode);
        end
        do_exec(2'b00, 1'b0, 1'b0, 32'h0, 0);
        checks++;
        if (pc !== 32'h4) begin
            errors++;
            $display("FAIL seq_pc: pc=%h, required 00000004", pc);
        end
    endtask

    task automatic test_branch();
        goto_pc(32'h10);
        do_fetch(32'h1000_FFFE, 1);
        do_exec(2'b00, 1'b1, 1'b1, 32'h0, 1);
        checks++;
        if (pc !== 32'h0C) begin
            errors++;
            $display("FAIL beq_taken: pc=%h, required 0000000c", pc);
        end
        goto_pc(32'h10);
        do_fetch(32'h1000_FFFE, 0);
        do_exec(2'b00, 1'b1, 1'b0, 32'h0, 0);
        checks++;
        if (pc !== 32'h14) begin
            errors++;
            $display("FAIL beq_not_taken: pc=%h, required 00000014", pc);
        end
        goto_pc(32'h10);
        do_fetch(32'h1400_FFFE, 2);
        do_exec(2'b00, 1'b1, 1'b0, 32'h0, 2);
        checks++;
        if (pc !== 32'h0C) begin
            errors++;
            $display("FAIL bne_taken: pc=%h, required 0000000c", pc);
        end
    endtask

    task automatic test_jump();
        goto_pc(32'h4000_0000);
        do_fetch(32'h0800_0010, 0);
        do_exec(2'b01, 1'b0, 1'b0, 32'h0, 3);
        checks++;
        if (pc !== 32'h4000_0040) begin
            errors++;
            $display("FAIL jump_pc: pc=%h, required 40000040", pc);
        end
    endtask

    task automatic test_jr();
        do_fetch(32'h0000_0008, 0);
        do_exec(2'b10, 1'b0, 1'b0, 32'h100, 0);
        checks++;
        if (pc !== 32'h100) begin
            errors++;
            $display("FAIL jr_pc: pc=%h, required 00000100", pc);
        end
        do_fetch(32'h0000_0008, 0);
        do_exec(2'b10, 1'b0, 1'b0, 32'h102, 0);
        for (int i = 0; i < 6; i++) begin
            imem_ack = 1'b1;
            ex_done  = 1'b1;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        ex_done  = 1'b0;
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h100) begin
            errors++;
            $display("FAIL jr_halt: err=%b req=%b valid=%b pc=%h, required err=1 req=0 valid=0 pc=100",
                     fetch_err, imem_req, instr_valid, pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [5:0]  ops [6];
        ops[0] = 6'h00; ops[1] = 6'h04; ops[2] = 6'h05;
        ops[3] = 6'h02; ops[4] = 6'h08; ops[5] = 6'h23;
        for (int n = 0; n < 60; n++) begin
            w = {ops[$urandom_range(0, 5)], 26'($urandom)};
            do_fetch(w, $urandom_range(0, 3));
            do_exec(2'($urandom), 1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC,
                    $urandom_range(0, 2));
        end
    endtask

    task automatic test_wrap();
        goto_pc(32'hFFFF_FFFC);
        do_fetch(32'h0000_0020, 0);
        checks++;
        if (pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc4: pc_plus4=%h, required 00000000", pc_plus4);
        end
        do_exec(2'b11, 1'b0, 1'b0, 32'h0, 0);
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: pc=%h, required 00000000", pc);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_early: err=%b req=%b after 3 cycles, required err=0 req=1",
                     fetch_err, imem_req);
        end
        @(negedge clk);
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_limit: err=%b req=%b after 4 cycles, required err=1 req=0",
                     fetch_err, imem_req);
        end
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL stall_halt: err=%b req=%b valid=%b pc=%h, required 1 0 0 00000000",
                     fetch_err, imem_req, instr_valid, pc);
        end
    endtask

    initial begin
        model_pc    = 32'h0;
        model_instr = 32'h0;
        model_halt  = 1'b0;
        @(negedge clk);
        test_reset();
        test_seq();
        test_branch();
        test_jump();
        test_jr();
        apply_reset();
        test_random();
        test_wrap();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
